// File: rtl/fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_pkg: shared output-mode constants and pointer sizing for fifo2.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width is never allowed to collapse to zero bits.
    function automatic int fifo_ptr_w(input int depth);
        return ($clog2(depth) > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wrap_ptr.sv
// +----------------------------------------------------------------------------+
// | fifo_wrap_ptr: modulo-DEPTH index counter with synchronous clear.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PW   = fifo_ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Explicit wrap compare so DEPTH need not be a power of two.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fifo2.sv
// +----------------------------------------------------------------------------+
// | fifo2: single-clock FIFO, any depth >= 2, thresholds, sticky errors,       |
// | flush and FWFT / registered-read output. Rev 1.0                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo2
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FIFO_MODE_FWFT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             d_in,
    output logic [WIDTH-1:0]             d_out,
    output logic                         d_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = fifo_ptr_w(DEPTH);

    if (DEPTH < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH ||
        (FWFT != FIFO_MODE_FWFT && FWFT != FIFO_MODE_REG)) begin : g_bad_params
        $error("fifo2: illegal DEPTH / AF_LEVEL / AE_LEVEL / FWFT combination");
    end

    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Flags decode only the registered count, keeping inputs off flag paths.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign push_ok = push && !full && !clr;
    assign pop_ok  = pop && !empty && !clr;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (push && full) begin
                ovf_d = 1'b1;
            end
            if (pop && empty) begin
                unf_d = 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= d_in;
        end
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (push_ok),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (pop_ok),
        .ptr   (rd_ptr)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign d_out   = mem_q[rd_ptr];
        assign d_valid = !empty;
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q;
        logic             dvalid_q;

        // pop_ok is already low under clr, so a flush drops d_valid and holds d_out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else begin
                dvalid_q <= pop_ok;
                if (pop_ok) begin
                    dout_q <= mem_q[rd_ptr];
                end
            end
        end

        assign d_out   = dout_q;
        assign d_valid = dvalid_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo2.sv
// +----------------------------------------------------------------------------+
// | tb_fifo2: three fifo2 configurations on shared stimulus vs a queue model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo2;

    localparam int DEP [3] = '{16, 5, 4};
    localparam int AFL [3] = '{14, 4, 3};
    localparam int AEL [3] = '{2, 1, 1};
    localparam int FW  [3] = '{1, 1, 0};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr   = 1'b0;
    logic       push  = 1'b0;
    logic       pop   = 1'b0;
    logic [7:0] d_in  = 8'h00;

    logic [7:0] dq [3];
    logic       dv [3];
    logic       fl [3];
    logic       em [3];
    logic       af [3];
    logic       ae [3];
    logic       ov [3];
    logic       un [3];
    logic [4:0] cnt0;
    logic [2:0] cnt1;
    logic [2:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo2 #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop), .d_in(d_in),
        .d_out(dq[0]), .d_valid(dv[0]), .full(fl[0]), .empty(em[0]),
        .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt0),
        .overflow(ov[0]), .underflow(un[0])
    );

    fifo2 #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop), .d_in(d_in),
        .d_out(dq[1]), .d_valid(dv[1]), .full(fl[1]), .empty(em[1]),
        .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt1),
        .overflow(ov[1]), .underflow(un[1])
    );

    fifo2 #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop), .d_in(d_in),
        .d_out(dq[2]), .d_valid(dv[2]), .full(fl[2]), .empty(em[2]),
        .almost_full(af[2]), .almost_empty(ae[2]), .count(cnt2),
        .overflow(ov[2]), .underflow(un[2])
    );

    // Model: one queue of words tagged with their instance number (tag*256 + data).
    int         mq [$];
    bit         m_ov [3];
    bit         m_un [3];
    bit         m_dv [3];
    logic [7:0] m_do [3];

    function automatic int mcount(input int k);
        int n = 0;
        foreach (mq[i]) if (mq[i] / 256 == k) n++;
        return n;
    endfunction

    function automatic int mfront(input int k);
        foreach (mq[i]) if (mq[i] / 256 == k) return mq[i] % 256;
        return 0;
    endfunction

    task automatic mremove(input int k, input bit all_of_k);
        int  t [$];
        bit  done = 1'b0;
        foreach (mq[i]) begin
            if (mq[i] / 256 == k && (all_of_k || !done)) done = 1'b1;
            else t.push_back(mq[i]);
        end
        mq = t;
    endtask

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = 1'b0;
            m_un[k] = 1'b0;
            m_dv[k] = 1'b0;
            m_do[k] = 8'h00;
        end
    endtask

    task automatic model_step(input bit p, input bit o, input bit c, input logic [7:0] d);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = mcount(k);
            m_dv[k] = 1'b0;
            if (c) begin
                mremove(k, 1'b1);
                m_ov[k] = 1'b0;
                m_un[k] = 1'b0;
            end else begin
                if (p && n == DEP[k]) m_ov[k] = 1'b1;
                if (o && n == 0) m_un[k] = 1'b1;
                if (o && n != 0) begin
                    if (FW[k] == 0) begin
                        m_do[k] = 8'(mfront(k));
                        m_dv[k] = 1'b1;
                    end
                    mremove(k, 1'b0);
                end
                if (p && n != DEP[k]) mq.push_back(k * 256 + int'(d));
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step(push, pop, clr, d_in);
        end
    end

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t got=%0d expected=%0d", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int ac [3];
        int n;
        ac[0] = int'(cnt0);
        ac[1] = int'(cnt1);
        ac[2] = int'(cnt2);
        for (int k = 0; k < 3; k++) begin
            n = mcount(k);
            chk("count", k, ac[k], n);
            chk("full", k, int'(fl[k]), int'(n == DEP[k]));
            chk("empty", k, int'(em[k]), int'(n == 0));
            chk("almost_full", k, int'(af[k]), int'(n >= AFL[k]));
            chk("almost_empty", k, int'(ae[k]), int'(n <= AEL[k]));
            chk("overflow", k, int'(ov[k]), int'(m_ov[k]));
            chk("underflow", k, int'(un[k]), int'(m_un[k]));
            if (FW[k] != 0) begin
                chk("d_valid", k, int'(dv[k]), int'(n != 0));
                if (n != 0) chk("d_out", k, int'(dq[k]), mfront(k));
            end else begin
                chk("d_valid", k, int'(dv[k]), int'(m_dv[k]));
                chk("d_out", k, int'(dq[k]), int'(m_do[k]));
            end
        end
    end

    task automatic cyc(input bit p, input bit o, input bit c, input logic [7:0] d);
        @(negedge clk);
        #1;
        push = p;
        pop  = o;
        clr  = c;
        d_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_count", 0, int'(cnt0), 0);
        chk("rst_empty", 0, int'(em[0]), 1);
        chk("rst_full", 0, int'(fl[0]), 0);
        chk("rst_af", 0, int'(af[0]), 0);
        chk("rst_ae", 0, int'(ae[0]), 1);
        chk("rst_dvalid", 2, int'(dv[2]), 0);
        chk("rst_dout", 2, int'(dq[2]), 0);
        rst_n = 1'b1;

        // Fill the default instance, then drain it in order.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
            settle();
            chk("t1_count", 0, int'(cnt0), i + 1);
            chk("t1_ae", 0, int'(ae[0]), int'(i + 1 <= 2));
            chk("t1_af", 0, int'(af[0]), int'(i + 1 >= 14));
        end
        chk("t1_full", 0, int'(fl[0]), 1);
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("t1_data", 0, int'(dq[0]), i);
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
        settle();
        chk("t1_empty", 0, int'(em[0]), 1);
        chk("t1_ovf", 0, int'(ov[0]), 0);
        chk("t1_unf", 0, int'(un[0]), 0);

        // DEPTH=5: full + push + pop pops only; later pairs both succeed across the wrap.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        cyc(1'b1, 1'b1, 1'b0, 8'h20);
        settle();
        chk("t2_count_after_first", 1, int'(cnt1), 4);
        chk("t2_ovf", 1, int'(ov[1]), 1);
        for (int i = 1; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
        settle();
        chk("t2_count", 1, int'(cnt1), 4);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_data", 1, int'(dq[1]), 8'h28 + i);
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end

        // Sticky underflow survives a push, clears on flush.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        chk("t3_unf", 0, int'(un[0]), 1);
        chk("t3_count", 0, int'(cnt0), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        settle();
        chk("t3_unf_sticky", 0, int'(un[0]), 1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        settle();
        chk("t3_unf_clr", 0, int'(un[0]), 0);
        chk("t3_empty_clr", 0, int'(em[0]), 1);

        // Registered read: one-cycle d_valid, d_out held afterwards.
        cyc(1'b1, 1'b0, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        #4;
        chk("t4_dvalid_n1", 2, int'(dv[2]), 1);
        chk("t4_dout_n1", 2, int'(dq[2]), 8'h11);
        #10;
        chk("t4_dvalid_n2", 2, int'(dv[2]), 0);
        chk("t4_dout_n2", 2, int'(dq[2]), 8'h11);

        // Simultaneous push + pop at mid occupancy and on empty.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        cyc(1'b1, 1'b1, 1'b0, 8'h33);
        settle();
        chk("t5_count", 0, int'(cnt0), 3);
        chk("t5_head", 0, int'(dq[0]), 2);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h44);
        settle();
        chk("t5_empty_count", 0, int'(cnt0), 1);
        chk("t5_empty_unf", 0, int'(un[0]), 1);
        chk("t5_empty_data", 0, int'(dq[0]), 8'h44);

        // Asynchronous reset between edges.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
        settle();
        chk("t6_pre_count", 0, int'(cnt0), 7);
        rst_n = 1'b0;
        #1;
        chk("t6_count", 0, int'(cnt0), 0);
        chk("t6_empty", 0, int'(em[0]), 1);
        chk("t6_full", 1, int'(fl[1]), 0);
        chk("t6_ovf", 2, int'(ov[2]), 0);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h5A);
        settle();
        chk("t6_data", 0, int'(dq[0]), 8'h5A);
        chk("t6_data", 1, int'(dq[1]), 8'h5A);

        // Random traffic with occasional flush and async reset.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) < 3, 8'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
